// File: rtl/fsm_updown_counter.sv
// ---------------------------------------------------------------------------
// fsm_updown_counter
// Parametrised up/down counter driven by a four-state FSM (IDLE/UP/DOWN/SAT).
// Supports count enable, direction, synchronous parallel load with clamping,
// wrap-around or saturating bounds, and a registered terminal-count pulse.
//
// Parameters:
//   WIDTH    - counter width in bits (>= 2)
//   MAX_VAL  - terminal (highest) count value, 1 .. 2**WIDTH-1
//   SATURATE - 0: wrap at bounds, 1: hold at bounds (enters SAT)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   en       in   count enable, one step per cycle
//   dir      in   1 = up, 0 = down
//   load     in   synchronous parallel load strobe
//   load_val in   value captured on load (clamped to MAX_VAL)
//   count    out  current count (registered)
//   tc       out  one-cycle terminal-count pulse (registered)
//   state    out  FSM state: IDLE=0, UP=1, DOWN=2, SAT=3 (registered)
// ---------------------------------------------------------------------------
module fsm_updown_counter #(
   parameter int unsigned WIDTH    = 2,
   parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic [1:0]       state
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2,
      ST_SAT  = 2'd3
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] count_q;
   logic             tc_q;

   logic             at_max_c;
   logic             at_zero_c;
   logic [WIDTH-1:0] count_inc_c;
   logic [WIDTH-1:0] count_dec_c;
   logic [WIDTH-1:0] load_clamp_c;

   // Bound detection and step arithmetic shared by all FSM branches
   always_comb begin
      at_max_c     = (count_q == MAX_C);
      at_zero_c    = (count_q == '0);
      count_inc_c  = count_q + WIDTH'(1);
      count_dec_c  = count_q - WIDTH'(1);
      load_clamp_c = (load_val > MAX_C) ? MAX_C : load_val;
   end

   // Counter FSM: reset > load > enable; a bound step either wraps (tc pulse)
   // or parks in SAT, where tc fires only on the entering edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         tc_q    <= 1'b0;
      end else if (load) begin
         state_q <= ST_IDLE;
         count_q <= load_clamp_c;
         tc_q    <= 1'b0;
      end else if (!en) begin
         state_q <= ST_IDLE;
         tc_q    <= 1'b0;
      end else if (dir) begin
         if (at_max_c) begin
            if (SATURATE) begin
               state_q <= ST_SAT;
               tc_q    <= (state_q != ST_SAT);
            end else begin
               state_q <= ST_UP;
               count_q <= '0;
               tc_q    <= 1'b1;
            end
         end else begin
            state_q <= ST_UP;
            count_q <= count_inc_c;
            tc_q    <= 1'b0;
         end
      end else begin
         if (at_zero_c) begin
            if (SATURATE) begin
               state_q <= ST_SAT;
               tc_q    <= (state_q != ST_SAT);
            end else begin
               state_q <= ST_DOWN;
               count_q <= MAX_C;
               tc_q    <= 1'b1;
            end
         end else begin
            state_q <= ST_DOWN;
            count_q <= count_dec_c;
            tc_q    <= 1'b0;
         end
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign state = state_q;

endmodule

// File: tb/tb_fsm_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_fsm_updown_counter
// Directed bench for fsm_updown_counter. Three instances share one stimulus:
//   u_a: WIDTH=2, wrap          u_b: WIDTH=3, MAX_VAL=5, wrap
//   u_c: WIDTH=2, saturating
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_fsm_updown_counter;

   bit         clk = 1'b0;
   logic       rst;
   logic       en;
   logic       dir;
   logic       ld;
   logic [2:0] lv;

   logic [1:0] a_cnt;
   logic       a_tc;
   logic [1:0] a_st;
   logic [2:0] b_cnt;
   logic       b_tc;
   logic [1:0] b_st;
   logic [1:0] c_cnt;
   logic       c_tc;
   logic [1:0] c_st;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fsm_updown_counter #(.WIDTH(2)) u_a (
      .clk(clk), .reset(rst), .en(en), .dir(dir), .load(ld),
      .load_val(lv[1:0]), .count(a_cnt), .tc(a_tc), .state(a_st)
   );

   fsm_updown_counter #(.WIDTH(3), .MAX_VAL(5), .SATURATE(1'b0)) u_b (
      .clk(clk), .reset(rst), .en(en), .dir(dir), .load(ld),
      .load_val(lv), .count(b_cnt), .tc(b_tc), .state(b_st)
   );

   fsm_updown_counter #(.WIDTH(2), .SATURATE(1'b1)) u_c (
      .clk(clk), .reset(rst), .en(en), .dir(dir), .load(ld),
      .load_val(lv[1:0]), .count(c_cnt), .tc(c_tc), .state(c_st)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Up-count from reset: wrap instance vs saturating instance
   int a_up_cnt[5] = '{1, 2, 3, 0, 1};
   int a_up_tc [5] = '{0, 0, 0, 1, 0};
   int c_up_cnt[5] = '{1, 2, 3, 3, 3};
   int c_up_tc [5] = '{0, 0, 0, 1, 0};
   int c_up_st [5] = '{1, 1, 1, 3, 3};
   // Down wrap through 0 with MAX_VAL=5
   int b_dn_cnt[3] = '{0, 5, 4};
   int b_dn_tc [3] = '{0, 1, 0};

   initial begin
      rst = 1'b1; en = 1'b0; dir = 1'b0; ld = 1'b0; lv = 3'd0;
      tick();
      chk("rst_a_cnt", 32'(a_cnt), 0);
      chk("rst_a_st",  32'(a_st),  0);
      chk("rst_a_tc",  32'(a_tc),  0);
      chk("rst_b_cnt", 32'(b_cnt), 0);
      chk("rst_c_cnt", 32'(c_cnt), 0);
      chk("rst_c_st",  32'(c_st),  0);

      // Reset held while other inputs active: outputs stay at reset values
      en = 1'b1; dir = 1'b1; ld = 1'b1; lv = 3'd2;
      tick();
      chk("rsthold_a_cnt", 32'(a_cnt), 0);
      chk("rsthold_a_st",  32'(a_st),  0);

      // Count up 5 edges
      rst = 1'b0; ld = 1'b0; en = 1'b1; dir = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("up_a_cnt[%0d]", i), 32'(a_cnt), 32'(a_up_cnt[i]));
         chk($sformatf("up_a_tc[%0d]", i),  32'(a_tc),  32'(a_up_tc[i]));
         chk($sformatf("up_a_st[%0d]", i),  32'(a_st),  1);
         chk($sformatf("up_c_cnt[%0d]", i), 32'(c_cnt), 32'(c_up_cnt[i]));
         chk($sformatf("up_c_tc[%0d]", i),  32'(c_tc),  32'(c_up_tc[i]));
         chk($sformatf("up_c_st[%0d]", i),  32'(c_st),  32'(c_up_st[i]));
      end

      // Leave SAT by pointing away from the bound
      dir = 1'b0;
      tick();
      chk("satexit_c_cnt", 32'(c_cnt), 2);
      chk("satexit_c_st",  32'(c_st),  2);
      chk("satexit_c_tc",  32'(c_tc),  0);
      chk("dn_a_cnt",      32'(a_cnt), 0);
      chk("dn_a_st",       32'(a_st),  2);

      // Down wrap with non-power-of-two bound
      ld = 1'b1; lv = 3'd1; en = 1'b0;
      tick();
      chk("ld1_b_cnt", 32'(b_cnt), 1);
      chk("ld1_b_st",  32'(b_st),  0);
      ld = 1'b0; en = 1'b1; dir = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("dnw_b_cnt[%0d]", i), 32'(b_cnt), 32'(b_dn_cnt[i]));
         chk($sformatf("dnw_b_tc[%0d]", i),  32'(b_tc),  32'(b_dn_tc[i]));
         chk($sformatf("dnw_b_st[%0d]", i),  32'(b_st),  2);
      end

      // Load beats enable and clamps to MAX_VAL
      ld = 1'b1; lv = 3'd7; en = 1'b1; dir = 1'b1;
      tick();
      chk("clamp_b_cnt", 32'(b_cnt), 5);
      chk("clamp_b_st",  32'(b_st),  0);
      chk("clamp_b_tc",  32'(b_tc),  0);
      chk("ld_a_cnt",    32'(a_cnt), 3);

      // Reset beats load
      rst = 1'b1;
      tick();
      chk("rstld_b_cnt", 32'(b_cnt), 0);
      chk("rstld_b_st",  32'(b_st),  0);

      // Reset mid-count
      rst = 1'b0; ld = 1'b0; en = 1'b1; dir = 1'b1;
      tick();
      chk("mid_a_cnt0", 32'(a_cnt), 1);
      tick();
      chk("mid_a_cnt1", 32'(a_cnt), 2);
      rst = 1'b1;
      tick();
      chk("mid_rst_cnt", 32'(a_cnt), 0);
      chk("mid_rst_st",  32'(a_st),  0);
      rst = 1'b0;
      tick();
      chk("mid_a_cnt2", 32'(a_cnt), 1);
      tick();
      chk("mid_a_cnt3", 32'(a_cnt), 2);
      chk("mid_a_st",   32'(a_st),  1);

      // Enable drop holds count in IDLE, then toggle direction each edge
      en = 1'b0;
      tick();
      chk("hold_a_cnt0", 32'(a_cnt), 2);
      chk("hold_a_st0",  32'(a_st),  0);
      tick();
      chk("hold_a_cnt1", 32'(a_cnt), 2);
      chk("hold_a_st1",  32'(a_st),  0);
      en = 1'b1; dir = 1'b0;
      tick();
      chk("tog_a_cnt0", 32'(a_cnt), 1);
      chk("tog_a_st0",  32'(a_st),  2);
      dir = 1'b1;
      tick();
      chk("tog_a_cnt1", 32'(a_cnt), 2);
      chk("tog_a_st1",  32'(a_st),  1);
      dir = 1'b0;
      tick();
      chk("tog_a_cnt2", 32'(a_cnt), 1);
      chk("tog_a_st2",  32'(a_st),  2);

      // Load coinciding with a wrap step discards the wrap and tc
      dir = 1'b1;
      tick();
      tick();
      chk("prewrap_a_cnt", 32'(a_cnt), 3);
      ld = 1'b1; lv = 3'd1;
      tick();
      chk("ldwrap_a_cnt", 32'(a_cnt), 1);
      chk("ldwrap_a_tc",  32'(a_tc),  0);
      chk("ldwrap_a_st",  32'(a_st),  0);

      // Lower bound: saturate at 0, wrap from 0 to MAX_VAL
      ld = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; en = 1'b1; dir = 1'b0;
      tick();
      chk("lo_c_cnt0", 32'(c_cnt), 0);
      chk("lo_c_st0",  32'(c_st),  3);
      chk("lo_c_tc0",  32'(c_tc),  1);
      chk("lo_a_cnt0", 32'(a_cnt), 3);
      chk("lo_a_tc0",  32'(a_tc),  1);
      tick();
      chk("lo_c_cnt1", 32'(c_cnt), 0);
      chk("lo_c_st1",  32'(c_st),  3);
      chk("lo_c_tc1",  32'(c_tc),  0);
      chk("lo_a_cnt1", 32'(a_cnt), 2);
      chk("lo_a_tc1",  32'(a_tc),  0);
      en = 1'b0;
      tick();
      chk("lo_c_st2",  32'(c_st),  0);
      chk("lo_c_cnt2", 32'(c_cnt), 0);
      chk("lo_a_st2",  32'(a_st),  0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
